// File: rtl/cpu_defines.sv
// Shared CPU types: pipeline stall vector, addresses and controller state.
package cpu_defines;

  typedef logic [5:0]  Stall_t;
  typedef logic [31:0] Inst_addr_t;
  typedef logic [31:0] Word_t;

  typedef enum logic [1:0] {
    RUN,
    WAIT_BUS,
    FLUSH
  } Ctrl_state_t;

  // Highest requesting stage k freezes stages 0..k and bubbles stage k+1
  localparam Stall_t STALL_NONE     = 6'b000000;
  localparam Stall_t STALL_FROM_IF  = 6'b000011;
  localparam Stall_t STALL_FROM_ID  = 6'b000111;
  localparam Stall_t STALL_FROM_EX  = 6'b001111;
  localparam Stall_t STALL_FROM_MEM = 6'b011111;

endpackage

// File: rtl/stall_encode.sv
// Maps the four stage stall requests to a Stall_t; later stages win.
module stall_encode
  import cpu_defines::*;
(
  input  logic   req_if_i,
  input  logic   req_id_i,
  input  logic   req_ex_i,
  input  logic   req_mem_i,
  output Stall_t stall_o
);

  always_comb begin
    stall_o = STALL_NONE;
    priority case (1'b1)
      req_mem_i: stall_o = STALL_FROM_MEM;
      req_ex_i:  stall_o = STALL_FROM_EX;
      req_id_i:  stall_o = STALL_FROM_ID;
      req_if_i:  stall_o = STALL_FROM_IF;
      default:   stall_o = STALL_NONE;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall encoding, exception/ERET flush sequencing,
// stall/flush performance counters and a sticky stall watchdog.
module pipe_ctrl
  import cpu_defines::*;
#(
  parameter Word_t       EXCP_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned TIMEOUT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        if_bus_busy,
  input  logic        excp_valid,
  input  logic        excp_is_eret,
  input  Word_t       cp0_epc,
  output Stall_t      stall,
  output logic        flush,
  output Inst_addr_t  flush_pc,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic        stall_timeout
);

  localparam logic [TIMEOUT_W-1:0] WD_MAX =
    TIMEOUT_W'(STALL_TIMEOUT);

  Ctrl_state_t          state_q, state_d;
  Inst_addr_t           tgt_q, tgt_d;
  Inst_addr_t           pc_q, pc_d;
  logic [31:0]          sc_q, sc_d;
  logic [15:0]          fc_q, fc_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 to_q, to_d;
  Stall_t               req_stall;

  stall_encode u_enc (
    .req_if_i  (stallreq_if),
    .req_id_i  (stallreq_id),
    .req_ex_i  (stallreq_ex),
    .req_mem_i (stallreq_mem),
    .stall_o   (req_stall)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    pc_d    = pc_q;
    stall   = STALL_NONE;
    flush   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (excp_valid) begin
          stall = STALL_FROM_MEM;
          tgt_d = excp_is_eret ? cp0_epc : EXCP_VECTOR;
          if (if_bus_busy) begin
            state_d = WAIT_BUS;
          end else begin
            state_d = FLUSH;
            pc_d    = tgt_d;
          end
        end else begin
          stall = req_stall;
        end
      end
      WAIT_BUS: begin
        // Hold the pipe until the outstanding fetch retires
        stall = STALL_FROM_MEM;
        if (!if_bus_busy) begin
          state_d = FLUSH;
          pc_d    = tgt_q;
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    sc_d = sc_q;
    fc_d = fc_q;
    wd_d = '0;
    if (stall != STALL_NONE) begin
      sc_d = sc_q + 32'd1;
      wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    end
    if (state_q == FLUSH) begin
      fc_d = fc_q + 16'd1;
    end
    to_d = to_q | (wd_q == WD_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q   <= '0;
      pc_q    <= '0;
      sc_q    <= '0;
      fc_q    <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      pc_q    <= pc_d;
      sc_q    <= sc_d;
      fc_q    <= fc_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  assign flush_pc      = pc_q;
  assign stall_cycles  = sc_q;
  assign flush_count   = fc_q;
  assign stall_timeout = to_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int          TO  = 8;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id;
  logic        stallreq_ex, stallreq_mem;
  logic        if_bus_busy;
  logic        excp_valid, excp_is_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic        stall_timeout;

  int errs;
  int checks;

  bit          m_pend, m_flush, m_to;
  logic [31:0] m_tgt, m_last, m_sc;
  logic [15:0] m_fc;
  int          m_run;

  pipe_ctrl #(
    .EXCP_VECTOR   (VEC),
    .STALL_TIMEOUT (TO),
    .TIMEOUT_W     (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .if_bus_busy   (if_bus_busy),
    .excp_valid    (excp_valid),
    .excp_is_eret  (excp_is_eret),
    .cp0_epc       (cp0_epc),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .stall_timeout (stall_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Highest requesting stage k: freeze k+2 low bits
  function automatic logic [5:0] enc(input logic [3:0] r);
    int k;
    k = -1;
    for (int i = 0; i < 4; i++)
      if (r[i]) k = i;
    if (k < 0) return 6'd0;
    return 6'((1 << (k + 2)) - 1);
  endfunction

  function automatic logic [5:0] exp_stall();
    if (m_flush) return 6'd0;
    if (m_pend) return 6'h1F;
    if (excp_valid) return 6'h1F;
    return enc({stallreq_mem, stallreq_ex,
                stallreq_id, stallreq_if});
  endfunction

  task automatic model_reset();
    m_pend  = 0;
    m_flush = 0;
    m_to    = 0;
    m_tgt   = '0;
    m_last  = '0;
    m_sc    = '0;
    m_fc    = '0;
    m_run   = 0;
  endtask

  task automatic model_edge();
    logic [5:0] s;
    s = exp_stall();
    if (m_run >= TO) m_to = 1;
    m_run = (s != 0) ? m_run + 1 : 0;
    if (s != 0) m_sc = m_sc + 1;
    if (m_flush) begin
      m_fc    = m_fc + 1;
      m_last  = m_tgt;
      m_flush = 0;
      m_pend  = 0;
    end else if (m_pend) begin
      if (!if_bus_busy) m_flush = 1;
    end else if (excp_valid) begin
      m_tgt = excp_is_eret ? cp0_epc : VEC;
      if (!if_bus_busy) m_flush = 1;
      else m_pend = 1;
    end
  endtask

  task automatic cmp();
    chk("stall", 32'(stall), 32'(exp_stall()));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("flush_pc", flush_pc,
        m_flush ? m_tgt : m_last);
    chk("stall_cycles", stall_cycles, m_sc);
    chk("flush_count", 32'(flush_count), 32'(m_fc));
    chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
  endtask

  // Drive one cycle's inputs and compare at the falling edge
  task automatic go(input logic [3:0] req,
                    input logic ex, input logic er,
                    input logic busy,
                    input logic [31:0] epc);
    stallreq_if  = req[0];
    stallreq_id  = req[1];
    stallreq_ex  = req[2];
    stallreq_mem = req[3];
    excp_valid   = ex;
    excp_is_eret = er;
    if_bus_busy  = busy;
    cp0_epc      = epc;
    @(negedge clk);
    cmp();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    go(4'b0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst    = 1'b1;
    model_reset();
    stallreq_if  = 0;
    stallreq_id  = 0;
    stallreq_ex  = 0;
    stallreq_mem = 0;
    excp_valid   = 0;
    excp_is_eret = 0;
    if_bus_busy  = 0;
    cp0_epc      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and priority
    idle();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush_pc", flush_pc, 32'h0);
    chk("rst_cnt", stall_cycles, 32'h0);
    tick();
    go(4'b0110, 0, 0, 0, 32'h0);
    chk("prio_id_ex", 32'(stall), 32'h0F);
    tick();
    idle();
    chk("release", 32'(stall), 32'h0);
    chk("sc_one", stall_cycles, 32'd1);
    tick();

    // Exception with idle bus
    go(4'b0, 1, 0, 0, 32'h1234_5678);
    chk("excp_stall", 32'(stall), 32'h1F);
    tick();
    idle();
    chk("excp_flush", 32'(flush), 32'h1);
    chk("excp_pc", flush_pc, 32'hBFC0_0380);
    chk("excp_fl_stall", 32'(stall), 32'h0);
    tick();
    idle();
    chk("excp_done", 32'(flush), 32'h0);
    chk("excp_fc", 32'(flush_count), 32'd1);
    tick();

    // ERET while fetch outstanding for 3 cycles
    go(4'b0, 1, 1, 1, 32'h8000_1234);
    chk("eret_s0", 32'(stall), 32'h1F);
    tick();
    for (int i = 0; i < 2; i++) begin
      go(4'b0, 1, 0, 1, 32'h0);
      chk("eret_wait", 32'(stall), 32'h1F);
      chk("eret_noflush", 32'(flush), 32'h0);
      tick();
    end
    go(4'b1000, 0, 0, 0, 32'h0);
    chk("eret_s3", 32'(stall), 32'h1F);
    chk("eret_noflush3", 32'(flush), 32'h0);
    tick();
    idle();
    chk("eret_flush", 32'(flush), 32'h1);
    chk("eret_pc", flush_pc, 32'h8000_1234);
    tick();
    idle();
    chk("eret_once", 32'(flush), 32'h0);
    chk("eret_fc", 32'(flush_count), 32'd2);
    chk("eret_pc_hold", flush_pc, 32'h8000_1234);
    tick();

    // MEM stall request together with an exception
    go(4'b1000, 1, 0, 0, 32'h0);
    chk("simul_stall", 32'(stall), 32'h1F);
    tick();
    go(4'b1000, 0, 0, 0, 32'h0);
    chk("simul_flush", 32'(flush), 32'h1);
    tick();
    repeat (2) begin idle(); tick(); end

    // Watchdog: 7 stalled cycles do not trip it
    repeat (7) begin go(4'b0100, 0, 0, 0, 32'h0); tick(); end
    repeat (3) begin idle(); tick(); end
    chk("wd_7", 32'(stall_timeout), 32'h0);
    repeat (9) begin go(4'b0100, 0, 0, 0, 32'h0); tick(); end
    repeat (2) begin idle(); tick(); end
    idle();
    chk("wd_9", 32'(stall_timeout), 32'h1);
    tick();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      logic [3:0] r;
      r[0] = ($urandom_range(0, 3) == 0);
      r[1] = ($urandom_range(0, 3) == 0);
      r[2] = ($urandom_range(0, 4) == 0);
      r[3] = ($urandom_range(0, 5) == 0);
      go(r, $urandom_range(0, 7) == 0,
         1'($urandom), 1'($urandom), $urandom);
      tick();
    end
    chk("wd_sticky", 32'(stall_timeout), 32'h1);

    // Async reset while waiting on the bus
    idle();
    tick();
    go(4'b0, 1, 0, 1, 32'h0);
    tick();
    go(4'b0, 0, 0, 1, 32'h0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_cnt", stall_cycles, 32'h0);
    chk("arst_wd", 32'(stall_timeout), 32'h0);
    @(negedge clk);
    if_bus_busy = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("arst_noflush", 32'(flush), 32'h0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
